serdes_tx_ctrl: RTL and testbench
=================================

# serdes_tx_ctrl

Transmit-side sequencer for the SerDes 8b/10b path. It accepts bytes from an upstream valid/ready stream and paces them into the encoder at one symbol per `SYM_CYCLES` clocks. It drives the encoder's byte input and its load/output enable, which in turn starts the PISO. When no data is offered, it fills empty slots with an idle byte, and it can send a training preamble after link enable.

## Interface
- `SYM_CYCLES`, 10: clocks per symbol slot; legal range ≥3.
- `TRAIN_LEN`, 16: number of preamble symbols, ≥1.
- `TRAIN_BYTE`, 8'h5A: byte sent during the preamble.
- `IDLE_BYTE`, 8'hBC: byte sent in an empty RUN slot.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_enable`  in  1  link enable; sampled only at slot boundaries.
- `s_data`  in  8  upstream byte.
- `s_valid`  in  1  upstream byte valid.
- `s_ready`  out  1  byte accepted on the edge where `s_valid & s_ready`.
- `enc_din`  out  8  byte to the encoder.
- `enc_en`  out  1  encoder enable: low = load `enc_din`, high = output the codeword and start the PISO.
- `link_up`  out  1  high while in RUN.
- `idle_flag`  out  1  high while the current slot carries `IDLE_BYTE` or `TRAIN_BYTE`.
- `data_cnt`  out  16  count of accepted data bytes; wraps from 16'hFFFF to 0.

## Operation
- **States:** OFF, TRAIN, RUN.
- **Slot counter:** `slot` runs from 0 to `SYM_CYCLES-1`. In OFF it is held at `SYM_CYCLES-1`.
- **Boundary edge:** any clock edge where the state is TRAIN or RUN and `slot == SYM_CYCLES-1`.
- **OFF:**
  - Outputs: `enc_din=0`, `enc_en=0`, `s_ready=0`.
  - If `tx_enable=1`, the next state is TRAIN. When `SERDES_TX_TRAIN_EN` is not defined, the next state is RUN instead.
  - No byte is loaded on this transition edge.
- **At every boundary edge:**
  - If `tx_enable=0`: the next state is OFF, `enc_din` is cleared to 0, and no byte is accepted.
  - If `tx_enable=1`, TRAIN: `enc_din<=TRAIN_BYTE`, `train_cnt++`, and `idle_flag<=1`. The state moves to RUN on the boundary edge that loads the `TRAIN_LEN`-th byte. `train_cnt` is cleared whenever the state is OFF.
  - If `tx_enable=1`, RUN with `s_valid=1`: `enc_din<=s_data`, `data_cnt++`, `idle_flag<=0`.
  - If `tx_enable=1`, RUN with `s_valid=0`: `enc_din<=IDLE_BYTE`, `idle_flag<=1`.
- **`s_ready`:** equals `(state==RUN) & (slot==SYM_CYCLES-1) & tx_enable`. It is decoded from registers and `tx_enable` only, with no path from `s_valid`.
- **`enc_en`:** registered. It is high exactly while `slot==1` in TRAIN or RUN, and low at all other times.
- **Slot sequence:** `enc_din` is stable throughout slots 0..`SYM_CYCLES-1`. The encoder loads at the end of slot 0 and outputs at the end of slot 1.
- **`link_up`:** registered; equals `state==RUN`.

## Timing
- **Reset values:** OFF, `slot=SYM_CYCLES-1`, `train_cnt=0`, `data_cnt=0`, `enc_din=0`, `enc_en=0`, `s_ready=0`, `link_up=0`, `idle_flag=0`.
- **Reset mid-slot:** all of the above take effect immediately. A partially sent symbol is abandoned; no drain occurs.
- **Enable to first load:** `tx_enable` is sampled at edge E0 in OFF. The first byte loads at edge E0+1, and `enc_en` is high during cycle E0+2.
- **Accepted byte to encoder:** a byte accepted at boundary edge B has `enc_en` high in the cycle after B+1.
- **Throughput:** one byte per `SYM_CYCLES` clocks maximum. `s_ready` is high for 1 cycle per slot.
- **Dropping `tx_enable` mid-slot:** the current slot completes, including its `enc_en` pulse. OFF is entered at the next boundary.
- **Dropping `tx_enable` during TRAIN:** go to OFF. The next enable restarts the full preamble.
- **Simultaneous `s_valid` and the boundary with `tx_enable=0`:** the byte is not accepted; `s_ready=0`.

## Configuration
- **`SERDES_TX_TRAIN_EN` defined:** the TRAIN state and `train_cnt` exist, and OFF→TRAIN sends `TRAIN_LEN` preamble symbols.
- **`SERDES_TX_TRAIN_EN` not defined:** no TRAIN state or `train_cnt` logic. OFF goes directly to RUN, and the first boundary may already accept data.

## Test plan
- **Reset values:** assert `reset=0` mid-run → all outputs return to their reset values in the same cycle; `data_cnt=0`.
- **Training, `SERDES_TX_TRAIN_EN` defined:** `tx_enable=1` with `s_valid=1` held → 16 slots with `enc_din=8'h5A`, `s_ready=0`, and `idle_flag=1`. Then `link_up=1`, and the first `s_ready` pulse arrives 10 clocks after the last train load.
- **Back-to-back data:** stream bytes 8'h00..8'h09 with `s_valid` always high → each byte is accepted 10 clocks apart, with one `enc_en` pulse per slot at `slot==1`; afterwards `data_cnt=10`.
- **Idle fill:** drop `s_valid` for 3 slots → `enc_din=8'hBC` and `idle_flag=1` for those slots; `data_cnt` is unchanged.
- **Disable mid-slot:** deassert `tx_enable` at `slot==4` → `enc_en` has already pulsed for that slot, OFF is entered at the boundary, `enc_din=0`, and no byte is accepted despite `s_valid=1`.
- **Counter wrap:** preload or run 65536 accepted bytes → `data_cnt` wraps to 0 without disturbing slot timing.

Source files
------------

// File: rtl/serdes_tx_ctrl_if.sv
// Upstream byte stream, link enable and encoder-side signals of the SerDes transmit sequencer.
// master = upstream/link-control side, slave = serdes_tx_ctrl.
interface serdes_tx_ctrl_if;
  logic        tx_enable;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  enc_din;
  logic        enc_en;
  logic        link_up;
  logic        idle_flag;
  logic [15:0] data_cnt;

  modport master (
    output tx_enable, s_data, s_valid,
    input  s_ready, enc_din, enc_en, link_up, idle_flag, data_cnt
  );

  modport slave (
    input  tx_enable, s_data, s_valid,
    output s_ready, enc_din, enc_en, link_up, idle_flag, data_cnt
  );
endinterface

// File: rtl/serdes_tx_ctrl.sv
// Transmit sequencer pacing upstream bytes into the 8b/10b encoder, one symbol per SYM_CYCLES clocks.
// Define SERDES_TX_TRAIN_EN to include the TRAIN preamble state; otherwise OFF goes straight to RUN.
module serdes_tx_ctrl #(
  parameter int unsigned SYM_CYCLES = 10,
  parameter int unsigned TRAIN_LEN  = 16,
  parameter logic [7:0]  TRAIN_BYTE = 8'h5A,
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
  input  logic            clk,
  input  logic            reset,
  serdes_tx_ctrl_if.slave bus
);

  localparam int unsigned       SLOT_W    = $clog2(SYM_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SYM_CYCLES - 1);

  if (SYM_CYCLES < 3 || TRAIN_LEN < 1) begin : g_bad_param
    $error("serdes_tx_ctrl: SYM_CYCLES must be >= 3 and TRAIN_LEN >= 1");
  end

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [7:0]        r_enc_din;
  logic              r_enc_en;
  logic              r_link_up;
  logic              r_idle_flag;
  logic [15:0]       r_data_cnt;

`ifdef SERDES_TX_TRAIN_EN
  localparam int unsigned   TC_W    = $clog2(TRAIN_LEN + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TRAIN_LEN - 1);
  logic [TC_W-1:0] r_train_cnt;
`endif

  logic       w_boundary;
  logic       w_s_ready;
  logic [7:0] w_fill_byte;

  assign w_boundary  = (r_state != ST_OFF) && (r_slot == SLOT_LAST);
  // Ready depends only on registered state and tx_enable, never on s_valid.
  assign w_s_ready   = (r_state == ST_RUN) && (r_slot == SLOT_LAST) && bus.tx_enable;
  assign w_fill_byte = (r_state == ST_RUN) ? IDLE_BYTE : TRAIN_BYTE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_OFF;
      r_slot      <= SLOT_LAST;
      r_enc_din   <= 8'h00;
      r_enc_en    <= 1'b0;
      r_link_up   <= 1'b0;
      r_idle_flag <= 1'b0;
      r_data_cnt  <= 16'h0000;
`ifdef SERDES_TX_TRAIN_EN
      r_train_cnt <= '0;
`endif
    end else begin
      // enc_en covers exactly the slot==1 cycle: encoder loads at end of slot 0, emits at end of slot 1.
      r_enc_en <= (r_state != ST_OFF) && (r_slot == '0);

      case (r_state)
        ST_OFF: begin
          r_slot      <= SLOT_LAST;
          r_enc_din   <= 8'h00;
          r_idle_flag <= 1'b0;
          r_link_up   <= 1'b0;
`ifdef SERDES_TX_TRAIN_EN
          r_train_cnt <= '0;
          if (bus.tx_enable) begin
            r_state <= ST_TRAIN;
          end
`else
          if (bus.tx_enable) begin
            r_state   <= ST_RUN;
            r_link_up <= 1'b1;
          end
`endif
        end

        default: begin
          if (!w_boundary) begin
            r_slot <= r_slot + 1'b1;
          end else if (!bus.tx_enable) begin
            // Slot finished with link disabled: park in OFF, nothing loaded or accepted.
            r_state     <= ST_OFF;
            r_enc_din   <= 8'h00;
            r_idle_flag <= 1'b0;
            r_link_up   <= 1'b0;
          end else begin
            r_slot <= '0;
            if (r_state == ST_RUN) begin
              if (bus.s_valid) begin
                r_enc_din   <= bus.s_data;
                r_idle_flag <= 1'b0;
                r_data_cnt  <= r_data_cnt + 16'd1;
              end else begin
                r_enc_din   <= w_fill_byte;
                r_idle_flag <= 1'b1;
              end
            end
`ifdef SERDES_TX_TRAIN_EN
            else begin
              r_enc_din   <= w_fill_byte;
              r_idle_flag <= 1'b1;
              r_train_cnt <= r_train_cnt + 1'b1;
              if (r_train_cnt == TC_LAST) begin
                r_state   <= ST_RUN;
                r_link_up <= 1'b1;
              end
            end
`endif
          end
        end
      endcase
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.enc_din   = r_enc_din;
  assign bus.enc_en    = r_enc_en;
  assign bus.link_up   = r_link_up;
  assign bus.idle_flag = r_idle_flag;
  assign bus.data_cnt  = r_data_cnt;

endmodule

// File: tb/tb_serdes_tx_ctrl.sv
// Bench for serdes_tx_ctrl: directed phases plus random traffic against a slot-level reference model.
module tb_serdes_tx_ctrl;

  localparam int         SC = 10;
  localparam int         TL = 16;
  localparam logic [7:0] TB = 8'h5A;
  localparam logic [7:0] IB = 8'hBC;
`ifdef SERDES_TX_TRAIN_EN
  localparam bit TRAIN_ON = 1'b1;
`else
  localparam bit TRAIN_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  serdes_tx_ctrl_if bus();

  serdes_tx_ctrl #(
    .SYM_CYCLES(SC),
    .TRAIN_LEN (TL),
    .TRAIN_BYTE(TB),
    .IDLE_BYTE (IB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: link mode (0 off, 1 train, 2 run), cycles into current slot, and slot contents.
  int          m_mode;
  int          m_pos;
  int          m_train;
  logic [7:0]  m_din;
  logic        m_idle;
  logic [15:0] m_cnt;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pos   = SC - 1;
    m_train = 0;
    m_din   = 8'h00;
    m_idle  = 1'b0;
    m_cnt   = 16'h0000;
  endtask

  task automatic model_edge(input logic te, input logic sv, input logic [7:0] sd);
    if (m_mode == 0) begin
      m_train = 0;
      if (te) m_mode = TRAIN_ON ? 1 : 2;
    end else if (m_pos != SC - 1) begin
      m_pos++;
    end else if (!te) begin
      m_mode = 0;
      m_din  = 8'h00;
      m_idle = 1'b0;
    end else begin
      m_pos = 0;
      if (m_mode == 1) begin
        m_din  = TB;
        m_idle = 1'b1;
        m_train++;
        if (m_train == TL) m_mode = 2;
      end else if (sv) begin
        m_din  = sd;
        m_idle = 1'b0;
        m_cnt  = m_cnt + 16'd1;
      end else begin
        m_din  = IB;
        m_idle = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".enc_din"},   bus.enc_din,   m_din);
    chk({tag, ".enc_en"},    bus.enc_en,    (m_mode != 0) && (m_pos == 1));
    chk({tag, ".link_up"},   bus.link_up,   m_mode == 2);
    chk({tag, ".idle_flag"}, bus.idle_flag, m_idle);
    chk({tag, ".data_cnt"},  bus.data_cnt,  m_cnt);
  endtask

  // One clock: drive at the falling edge, check ready, advance model at the rising edge, check at the next falling edge.
  task automatic step(input string tag, input logic te, input logic sv, input logic [7:0] sd);
    bus.tx_enable = te;
    bus.s_valid   = sv;
    bus.s_data    = sd;
    #1;
    chk({tag, ".s_ready"}, bus.s_ready, (m_mode == 2) && (m_pos == SC - 1) && te);
    @(posedge clk);
    model_edge(te, sv, sd);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic bring_up(input string tag);
    for (int k = 0; k < (TL + 3) * SC && !(m_mode == 2 && m_pos == SC - 1); k++)
      step(tag, 1'b1, TRAIN_ON, 8'($urandom));
    chk({tag, ".link_up_reached"}, bus.link_up, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          train_loads;
  logic [15:0] cnt_save;

  initial begin
    bus.tx_enable = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    model_reset();

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check_outputs("rst");
    chk("rst.s_ready", bus.s_ready, 1'b0);
    reset = 1'b1;

    for (int k = 0; k < 5; k++) step("off", 1'b0, 1'($urandom), 8'($urandom));

    // Enable: preamble (when built in) then RUN, with s_valid held high during training.
    train_loads = 0;
    for (int k = 0; k < (TL + 3) * SC && !(m_mode == 2 && m_pos == SC - 1); k++) begin
      step("train", 1'b1, TRAIN_ON, 8'($urandom));
      if (bus.enc_en && bus.enc_din == TB && bus.idle_flag) train_loads++;
    end
    chk("train.link_up", bus.link_up, 1'b1);
`ifdef SERDES_TX_TRAIN_EN
    chk("train.symbols", train_loads, TL);
`endif
    chk("train.no_accept", bus.data_cnt, 16'd0);

    // Back-to-back data bytes 0..9.
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < SC; c++) step("b2b", 1'b1, 1'b1, 8'(b));
    chk("b2b.data_cnt", bus.data_cnt, 16'd10);
    chk("b2b.last_byte", bus.enc_din, 8'h09);

    // Idle fill for three slots.
    for (int c = 0; c < 3 * SC; c++) step("idle", 1'b1, 1'b0, 8'($urandom));
    chk("idle.data_cnt", bus.data_cnt, 16'd10);
    chk("idle.enc_din", bus.enc_din, IB);
    chk("idle.flag", bus.idle_flag, 1'b1);

    // Random traffic with link held up.
    for (int c = 0; c < 40 * SC; c++)
      step("rand", 1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom));

    // Disable at slot 4 while s_valid stays high.
    for (int k = 0; k < SC && m_pos != 4; k++) step("dis_align", 1'b1, 1'b1, 8'($urandom));
    cnt_save = m_cnt;
    for (int c = 0; c < 2 * SC; c++) step("disable", 1'b0, 1'b1, 8'($urandom));
    chk("disable.link_up", bus.link_up, 1'b0);
    chk("disable.enc_din", bus.enc_din, 8'h00);
    chk("disable.data_cnt", bus.data_cnt, cnt_save);

    // Re-enable, run a little, then async reset in the middle of a slot.
    bring_up("reen");
    for (int c = 0; c < 3 * SC + 5; c++) step("reen_run", 1'b1, 1'b1, 8'($urandom));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    chk("midrst.s_ready", bus.s_ready, 1'b0);
    chk("midrst.data_cnt_zero", bus.data_cnt, 16'd0);
    @(negedge clk);
    check_outputs("midrst_hold");
    reset = 1'b1;

    // Random link toggling, including drops during training.
    for (int c = 0; c < 60 * SC; c++)
      step("rand_te", 1'($urandom_range(0, 40) != 0), 1'($urandom), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
